store_rs_param: RTL and testbench
=================================

# store_rs_param

Parametrised store reservation station for the Tomasulo core. Sits between the dispatch stage and the store/memory unit. It buffers up to DEPTH store instructions and captures the store value and base address from any of CDB_PORTS common data buses. It issues ready stores as (value, base+offset, ROB tag) through a valid/ready handshake. It extends the fixed 4-entry, 2-CDB station with configurable depth and port count, age tracking, an in-order or oldest-ready issue mode, back-pressure, dispatch-time CDB bypass and flush.

## Interface
Parameters:
- DEPTH, 4, number of entries (2..16)
- XLEN, 32, data/address width
- TAG_W, 6, ROB tag width
- CDB_PORTS, 2, number of broadcast buses
- TAG_NONE, 6'd16, sentinel tag meaning "operand already valid"
- IN_ORDER, 1, 1 = only the oldest entry may issue; 0 = oldest ready entry issues

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries and the output register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry free (count < DEPTH)
- disp_data  in  XLEN  store value (valid when disp_q_data == TAG_NONE)
- disp_q_data  in  TAG_W  producer tag of the store value
- disp_base  in  XLEN  base address (valid when disp_q_base == TAG_NONE)
- disp_q_base  in  TAG_W  producer tag of the base
- disp_offset  in  XLEN  sign-extended immediate
- disp_rob  in  TAG_W  ROB entry of this store
- cdb_valid  in  CDB_PORTS  per-port broadcast strobe
- cdb_tag  in  CDB_PORTS*TAG_W  packed tags, port 0 in LSBs
- cdb_data  in  CDB_PORTS*XLEN  packed results
- issue_valid  out  1  registered store available
- issue_ready  in  1  store unit accepts
- issue_data  out  XLEN  store value
- issue_addr  out  XLEN  base + offset
- issue_rob  out  TAG_W  ROB tag
- count  out  $clog2(DEPTH+1)  occupied entries, not counting the output register

## Operation
- Each entry holds: busy, value, q_value, base, q_base, offset, rob, and age (0 = oldest).
- Dispatch (disp_valid && disp_ready): the lowest-index free entry is written.
  - Its age is set to the current count.
  - Bypass: if any cdb_valid[p] has cdb_tag[p] == a disp_q_* that is not TAG_NONE, that operand is captured from cdb_data[p] and its q is set to TAG_NONE.
- Wakeup: for every busy entry and every valid port, a q matching cdb_tag (not TAG_NONE) captures the data and clears q to TAG_NONE.
  - If several ports carry the same tag in one cycle, the lowest port index wins.
- Ready: busy && q_value == TAG_NONE && q_base == TAG_NONE.
- Select:
  - IN_ORDER=1: only the age-0 entry is a candidate, and only if it is ready.
  - IN_ORDER=0: the ready entry with the lowest age.
- Issue register load: when (!issue_valid || issue_ready) and a candidate exists:
  - load issue_data, issue_addr = base + offset (mod 2^XLEN, carry dropped) and issue_rob;
  - free the entry;
  - decrement the age of every entry older-numbered (greater age) than the freed one.
- Dispatch, load and wakeup can all happen in the same cycle.
  - A newly dispatched entry's age accounts for the same-cycle free: age = count - 1 if a free occurs that cycle.
- flush (when reset is deasserted): all busy flags, issue_valid and count go to 0 at the edge. Dispatch in the same cycle is dropped.
- A tag equal to TAG_NONE on a CDB port never matches.

## Timing
- Reset values: issue_valid=0, issue_data=0, issue_addr=0, issue_rob=TAG_NONE, count=0, disp_ready=1, all entries not busy.
- disp_ready is combinational from count only. A same-cycle free does not raise it.
- Dispatch at edge k with both operands valid or bypassed: earliest issue_valid is after edge k+1.
- CDB wakeup at edge k: earliest issue_valid is after edge k+1.
- issue_valid && !issue_ready: all issue_* outputs are held stable and no entry is freed.
- With issue_ready held high: one store per cycle.
- Full (count == DEPTH): disp_valid is ignored.
- Reset asserted mid-handshake clears immediately, independent of clock.

## Structure
- Package store_rs_pkg holds the entry struct, TAG_NONE default, and the swOp opcode constant shared with dispatch.
- One sub-module, rs_cdb_match: one operand's (q, data) against all ports, returning the captured data and the new q. It is instantiated twice per entry and twice at dispatch.
- Age update and select are inline priority logic.

## Test plan
- Reset, dispatch a store with value 0xDEADBEEF, base 0x1000, offset 0x10, both tags TAG_NONE, rob 3, issue_ready=1 -> issue_valid after the next edge with addr 0x1010, data 0xDEADBEEF, rob 3; count returns to 0.
- Fill DEPTH=4 entries with q_value=5, then try a 5th dispatch -> disp_ready=0 and the 5th is ignored. Broadcast tag 5 / 0x77 on port 1 -> all four issue in dispatch order on successive cycles.
- IN_ORDER=1: entry A waits on tag 7, younger entry B is ready -> nothing issues. After tag 7 is broadcast -> A issues, then B.
- IN_ORDER=0, same setup -> B issues first; A issues after tag 7.
- Ports 0 and 1 both broadcast tag 9 (data 0x1 / 0x2) in the same cycle as a dispatch with q_base=9 -> base captured = 0x1.
- Hold issue_ready=0 for 3 cycles with a pending store -> outputs stable. Assert flush -> issue_valid=0, count=0. Pulse reset low mid-cycle -> all outputs at reset values immediately.

Source files
------------

// File: rtl/store_rs_pkg.sv
// Shared types and constants for the store reservation station.
// Entry control state lives here; payload widths follow the instantiating module.
package store_rs_pkg;

    localparam logic [5:0]  TagNoneDefault = 6'd16;
    localparam logic [6:0]  SwOp           = 7'b0100011;
    localparam int unsigned MaxAgeW        = 4;

    // Age 0 is the oldest busy entry; ages of busy entries are always unique.
    typedef struct packed {
        logic               busy;
        logic [MaxAgeW-1:0] age;
    } rs_ctrl_t;

endpackage

// File: rtl/rs_cdb_match.sv
// Matches one waiting operand against every CDB port and captures its data.
// The lowest-numbered port wins when several carry the same tag.
module rs_cdb_match #(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      TAG_W     = 6,
    parameter int unsigned      CDB_PORTS = 2,
    parameter logic [TAG_W-1:0] TAG_NONE  = TAG_W'(16)
) (
    input  logic [TAG_W-1:0]           q_i,
    input  logic [XLEN-1:0]            data_i,
    input  logic [CDB_PORTS-1:0]       cdb_valid_i,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag_i,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_data_i,
    output logic [TAG_W-1:0]           q_o,
    output logic [XLEN-1:0]            data_o
);

    logic hit;

    always_comb begin
        hit    = 1'b0;
        q_o    = q_i;
        data_o = data_i;
        if (q_i != TAG_NONE) begin
            for (int unsigned p = 0; p < CDB_PORTS; p++) begin
                if (!hit && cdb_valid_i[p] && (cdb_tag_i[p*TAG_W +: TAG_W] == q_i)) begin
                    hit    = 1'b1;
                    q_o    = TAG_NONE;
                    data_o = cdb_data_i[p*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/store_rs_param.sv
// Parametrised store reservation station: buffers stores, wakes operands from the CDB
// and issues (value, base+offset, rob) through a registered valid/ready output.
module store_rs_param
    import store_rs_pkg::*;
#(
    parameter int unsigned      DEPTH     = 4,
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      TAG_W     = 6,
    parameter int unsigned      CDB_PORTS = 2,
    parameter logic [TAG_W-1:0] TAG_NONE  = TAG_W'(TagNoneDefault),
    parameter bit               IN_ORDER  = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [XLEN-1:0]              disp_data,
    input  logic [TAG_W-1:0]             disp_q_data,
    input  logic [XLEN-1:0]              disp_base,
    input  logic [TAG_W-1:0]             disp_q_base,
    input  logic [XLEN-1:0]              disp_offset,
    input  logic [TAG_W-1:0]             disp_rob,
    input  logic [CDB_PORTS-1:0]         cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]   cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]    cdb_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [XLEN-1:0]              issue_data,
    output logic [XLEN-1:0]              issue_addr,
    output logic [TAG_W-1:0]             issue_rob,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned AGE_W = MaxAgeW;

    rs_ctrl_t         ctrl_q   [DEPTH];
    rs_ctrl_t         ctrl_d   [DEPTH];
    logic [XLEN-1:0]  value_q  [DEPTH];
    logic [XLEN-1:0]  value_d  [DEPTH];
    logic [TAG_W-1:0] qv_q     [DEPTH];
    logic [TAG_W-1:0] qv_d     [DEPTH];
    logic [XLEN-1:0]  base_q   [DEPTH];
    logic [XLEN-1:0]  base_d   [DEPTH];
    logic [TAG_W-1:0] qb_q     [DEPTH];
    logic [TAG_W-1:0] qb_d     [DEPTH];
    logic [XLEN-1:0]  offset_q [DEPTH];
    logic [XLEN-1:0]  offset_d [DEPTH];
    logic [TAG_W-1:0] rob_q    [DEPTH];
    logic [TAG_W-1:0] rob_d    [DEPTH];

    logic [XLEN-1:0]  value_wk [DEPTH];
    logic [TAG_W-1:0] qv_wk    [DEPTH];
    logic [XLEN-1:0]  base_wk  [DEPTH];
    logic [TAG_W-1:0] qb_wk    [DEPTH];
    logic [DEPTH-1:0] entry_ready;

    logic [XLEN-1:0]  disp_value_cap, disp_base_cap;
    logic [TAG_W-1:0] disp_qv_cap, disp_qb_cap;

    logic [CNT_W-1:0] count_q, count_d;
    logic             issue_valid_q, issue_valid_d;
    logic [XLEN-1:0]  issue_data_q, issue_data_d;
    logic [XLEN-1:0]  issue_addr_q, issue_addr_d;
    logic [TAG_W-1:0] issue_rob_q, issue_rob_d;

    logic             cand_found, free_found, issue_load, do_disp;
    logic [IDX_W-1:0] cand_idx, free_idx;
    logic [AGE_W-1:0] cand_age, new_age;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        rs_cdb_match #(
            .XLEN(XLEN), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS), .TAG_NONE(TAG_NONE)
        ) u_match_value (
            .q_i(qv_q[i]), .data_i(value_q[i]), .cdb_valid_i(cdb_valid),
            .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data), .q_o(qv_wk[i]), .data_o(value_wk[i])
        );
        rs_cdb_match #(
            .XLEN(XLEN), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS), .TAG_NONE(TAG_NONE)
        ) u_match_base (
            .q_i(qb_q[i]), .data_i(base_q[i]), .cdb_valid_i(cdb_valid),
            .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data), .q_o(qb_wk[i]), .data_o(base_wk[i])
        );
        assign entry_ready[i] = ctrl_q[i].busy && (qv_q[i] == TAG_NONE) && (qb_q[i] == TAG_NONE);
    end

    rs_cdb_match #(
        .XLEN(XLEN), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS), .TAG_NONE(TAG_NONE)
    ) u_disp_value (
        .q_i(disp_q_data), .data_i(disp_data), .cdb_valid_i(cdb_valid),
        .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data), .q_o(disp_qv_cap), .data_o(disp_value_cap)
    );

    rs_cdb_match #(
        .XLEN(XLEN), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS), .TAG_NONE(TAG_NONE)
    ) u_disp_base (
        .q_i(disp_q_base), .data_i(disp_base), .cdb_valid_i(cdb_valid),
        .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data), .q_o(disp_qb_cap), .data_o(disp_base_cap)
    );

    // Candidate selection and lowest free slot.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_age   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (IN_ORDER) begin
                if (entry_ready[i] && (ctrl_q[i].age == '0)) begin
                    cand_found = 1'b1;
                    cand_idx   = IDX_W'(i);
                    cand_age   = '0;
                end
            end else if (entry_ready[i] && (!cand_found || (ctrl_q[i].age < cand_age))) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
                cand_age   = ctrl_q[i].age;
            end
            if (!free_found && !ctrl_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign do_disp    = disp_valid && disp_ready && free_found && !flush;
    assign issue_load = cand_found && (!issue_valid_q || issue_ready);
    // The new entry sits behind everything still present after this cycle's free.
    assign new_age    = issue_load ? AGE_W'(count_q - 1'b1) : AGE_W'(count_q);

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ctrl_d[i]   = ctrl_q[i];
            value_d[i]  = value_wk[i];
            qv_d[i]     = qv_wk[i];
            base_d[i]   = base_wk[i];
            qb_d[i]     = qb_wk[i];
            offset_d[i] = offset_q[i];
            rob_d[i]    = rob_q[i];
            if (issue_load && ctrl_q[i].busy && (ctrl_q[i].age > cand_age)) begin
                ctrl_d[i].age = ctrl_q[i].age - 1'b1;
            end
            if (issue_load && (cand_idx == IDX_W'(i))) begin
                ctrl_d[i].busy = 1'b0;
            end
            if (do_disp && (free_idx == IDX_W'(i))) begin
                ctrl_d[i].busy = 1'b1;
                ctrl_d[i].age  = new_age;
                value_d[i]     = disp_value_cap;
                qv_d[i]        = disp_qv_cap;
                base_d[i]      = disp_base_cap;
                qb_d[i]        = disp_qb_cap;
                offset_d[i]    = disp_offset;
                rob_d[i]       = disp_rob;
            end
            if (flush) begin
                ctrl_d[i].busy = 1'b0;
            end
        end
    end

    always_comb begin
        count_d       = count_q + CNT_W'(do_disp) - CNT_W'(issue_load);
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        issue_addr_d  = issue_addr_q;
        issue_rob_d   = issue_rob_q;
        if (issue_load) begin
            issue_valid_d = 1'b1;
            issue_data_d  = value_q[cand_idx];
            issue_addr_d  = base_q[cand_idx] + offset_q[cand_idx];
            issue_rob_d   = rob_q[cand_idx];
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end
        if (flush) begin
            count_d       = '0;
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrl_q[i]   <= '0;
                value_q[i]  <= '0;
                qv_q[i]     <= TAG_NONE;
                base_q[i]   <= '0;
                qb_q[i]     <= TAG_NONE;
                offset_q[i] <= '0;
                rob_q[i]    <= '0;
            end
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
            issue_addr_q  <= '0;
            issue_rob_q   <= TAG_NONE;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrl_q[i]   <= ctrl_d[i];
                value_q[i]  <= value_d[i];
                qv_q[i]     <= qv_d[i];
                base_q[i]   <= base_d[i];
                qb_q[i]     <= qb_d[i];
                offset_q[i] <= offset_d[i];
                rob_q[i]    <= rob_d[i];
            end
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
            issue_addr_q  <= issue_addr_d;
            issue_rob_q   <= issue_rob_d;
        end
    end

    assign count       = count_q;
    assign issue_valid = issue_valid_q;
    assign issue_data  = issue_data_q;
    assign issue_addr  = issue_addr_q;
    assign issue_rob   = issue_rob_q;

endmodule

// File: tb/tb_store_rs_param.sv
// Scoreboard bench: two stations (in-order and oldest-ready) share one stimulus stream,
// each with its own expected-issue queue drained by a monitor.
module tb_store_rs_param;

    localparam logic [5:0] TNONE = 6'd16;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic [5:0]  rob;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, flush, disp_valid, issue_ready;
    logic [31:0] disp_data, disp_base, disp_offset;
    logic [5:0]  disp_q_data, disp_q_base, disp_rob;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [63:0] cdb_data;

    logic        ino_ready, ino_valid, ooo_ready, ooo_valid;
    logic [31:0] ino_data, ino_addr, ooo_data, ooo_addr;
    logic [5:0]  ino_rob, ooo_rob;
    logic [2:0]  ino_count, ooo_count;

    exp_t q_ino[$];
    exp_t q_ooo[$];
    exp_t e_ino, e_ooo;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    store_rs_param #(.IN_ORDER(1'b1)) u_ino (
        .clock(clock), .reset(reset), .flush(flush), .disp_valid(disp_valid),
        .disp_ready(ino_ready), .disp_data(disp_data), .disp_q_data(disp_q_data),
        .disp_base(disp_base), .disp_q_base(disp_q_base), .disp_offset(disp_offset),
        .disp_rob(disp_rob), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(ino_valid), .issue_ready(issue_ready), .issue_data(ino_data),
        .issue_addr(ino_addr), .issue_rob(ino_rob), .count(ino_count)
    );

    store_rs_param #(.IN_ORDER(1'b0)) u_ooo (
        .clock(clock), .reset(reset), .flush(flush), .disp_valid(disp_valid),
        .disp_ready(ooo_ready), .disp_data(disp_data), .disp_q_data(disp_q_data),
        .disp_base(disp_base), .disp_q_base(disp_q_base), .disp_offset(disp_offset),
        .disp_rob(disp_rob), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(ooo_valid), .issue_ready(issue_ready), .issue_data(ooo_data),
        .issue_addr(ooo_addr), .issue_rob(ooo_rob), .count(ooo_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitors: every accepted issue must match the head of that station's queue.
    always @(negedge clock) begin
        if (reset === 1'b1 && issue_ready === 1'b1 && ino_valid === 1'b1) begin
            if (q_ino.size() == 0) begin
                n_total++;
                $display("FAIL ino_unexpected: got rob %0d, expected no issue", ino_rob);
            end else begin
                e_ino = q_ino.pop_front();
                chk("ino_data", ino_data, e_ino.data);
                chk("ino_addr", ino_addr, e_ino.addr);
                chk("ino_rob", 32'(ino_rob), 32'(e_ino.rob));
            end
        end
    end

    always @(negedge clock) begin
        if (reset === 1'b1 && issue_ready === 1'b1 && ooo_valid === 1'b1) begin
            if (q_ooo.size() == 0) begin
                n_total++;
                $display("FAIL ooo_unexpected: got rob %0d, expected no issue", ooo_rob);
            end else begin
                e_ooo = q_ooo.pop_front();
                chk("ooo_data", ooo_data, e_ooo.data);
                chk("ooo_addr", ooo_addr, e_ooo.addr);
                chk("ooo_rob", 32'(ooo_rob), 32'(e_ooo.rob));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 2'b00;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [31:0] d, input logic [5:0] qd, input logic [31:0] b,
                        input logic [5:0] qb, input logic [31:0] off, input logic [5:0] rob);
        disp_valid  = 1'b1;
        disp_data   = d;
        disp_q_data = qd;
        disp_base   = b;
        disp_q_base = qb;
        disp_offset = off;
        disp_rob    = rob;
    endtask

    task automatic push_both(input logic [31:0] d, input logic [31:0] a, input logic [5:0] r);
        exp_t e;
        e = '{data: d, addr: a, rob: r};
        q_ino.push_back(e);
        q_ooo.push_back(e);
    endtask

    task automatic chk_reset_vals(input string who, input logic v, input logic [31:0] d,
                                  input logic [31:0] a, input logic [5:0] r,
                                  input logic [2:0] c, input logic rdy);
        chk({who, "_rst_valid"}, 32'(v), 32'd0);
        chk({who, "_rst_data"}, d, 32'd0);
        chk({who, "_rst_addr"}, a, 32'd0);
        chk({who, "_rst_rob"}, 32'(r), 32'(TNONE));
        chk({who, "_rst_count"}, 32'(c), 32'd0);
        chk({who, "_rst_ready"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        issue_ready = 1'b1;
        disp('0, TNONE, '0, TNONE, '0, '0);
        disp_valid = 1'b0;
        cdb_tag    = '0;
        cdb_data   = '0;
        #12;
        chk_reset_vals("ino", ino_valid, ino_data, ino_addr, ino_rob, ino_count, ino_ready);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Single ready store: visible one edge after it lands.
        push_both(32'hDEADBEEF, 32'h1010, 6'd3);
        disp(32'hDEADBEEF, TNONE, 32'h1000, TNONE, 32'h10, 6'd3);
        tick();
        idle();
        chk("t1_count_after_disp", 32'(ino_count), 32'd1);
        chk("t1_not_yet_valid", 32'(ino_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(ino_valid), 32'd1);
        chk("t1_count_zero", 32'(ino_count), 32'd0);
        tick();
        chk("t1_drained", 32'(ino_valid), 32'd0);

        // Fill to DEPTH, reject a 5th, then one broadcast wakes all four.
        for (int i = 0; i < 4; i++) begin
            disp(32'h0, 6'd5, 32'h2000 + 32'(16 * i), TNONE, 32'h4, 6'(10 + i));
            push_both(32'h77, 32'h2004 + 32'(16 * i), 6'(10 + i));
            tick();
        end
        chk("t2_full_count", 32'(ino_count), 32'd4);
        chk("t2_full_not_ready", 32'(ino_ready), 32'd0);
        disp(32'h99, TNONE, 32'h5000, TNONE, 32'h0, 6'd14);
        tick();
        idle();
        chk("t2_fifth_ignored", 32'(ooo_count), 32'd4);
        cdb_valid = 2'b10;
        cdb_tag   = {6'd5, 6'd0};
        cdb_data  = {32'h77, 32'h0};
        tick();
        idle();
        chk("t2_woken_count", 32'(ino_count), 32'd4);
        repeat (4) tick();
        chk("t2_drain_count", 32'(ino_count), 32'd0);
        chk("t2_ready_again", 32'(ino_ready), 32'd1);
        tick();

        // Old entry A waits on tag 7; younger B is ready.
        q_ino.push_back('{data: 32'hAAAA, addr: 32'h3000, rob: 6'd20});
        q_ino.push_back('{data: 32'hB, addr: 32'h3100, rob: 6'd21});
        q_ooo.push_back('{data: 32'hB, addr: 32'h3100, rob: 6'd21});
        q_ooo.push_back('{data: 32'hAAAA, addr: 32'h3000, rob: 6'd20});
        disp(32'h0, 6'd7, 32'h3000, TNONE, 32'h0, 6'd20);
        tick();
        disp(32'hB, TNONE, 32'h3100, TNONE, 32'h0, 6'd21);
        tick();
        idle();
        repeat (3) tick();
        chk("t3_ino_blocked_valid", 32'(ino_valid), 32'd0);
        chk("t3_ino_blocked_count", 32'(ino_count), 32'd2);
        chk("t3_ooo_b_gone_count", 32'(ooo_count), 32'd1);
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, 6'd7};
        cdb_data  = {32'h0, 32'hAAAA};
        tick();
        idle();
        repeat (4) tick();
        chk("t3_ino_done", 32'(ino_count), 32'd0);
        chk("t3_ooo_done", 32'(ooo_count), 32'd0);

        // Dispatch bypass with two ports on one tag: port 0 wins.
        push_both(32'h55, 32'h5, 6'd30);
        disp(32'h55, TNONE, 32'hFFFF, 6'd9, 32'h4, 6'd30);
        cdb_valid = 2'b11;
        cdb_tag   = {6'd9, 6'd9};
        cdb_data  = {32'h2, 32'h1};
        tick();
        idle();
        // Address wraps; a TAG_NONE broadcast must not touch a ready operand.
        push_both(32'h66, 32'h10, 6'd31);
        disp(32'h66, TNONE, 32'hFFFF_FFF0, TNONE, 32'h20, 6'd31);
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, TNONE};
        cdb_data  = {32'h0, 32'hBAD};
        tick();
        idle();
        repeat (3) tick();

        // Back-pressure holds outputs and the queued entry; flush then clears everything.
        issue_ready = 1'b0;
        disp(32'h1234, TNONE, 32'h4000, TNONE, 32'h8, 6'd40);
        tick();
        disp(32'h4321, TNONE, 32'h4100, TNONE, 32'h8, 6'd41);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_hold_valid", 32'(ino_valid), 32'd1);
            chk("t5_hold_data", ino_data, 32'h1234);
            chk("t5_hold_addr", ooo_addr, 32'h4008);
            chk("t5_hold_rob", 32'(ino_rob), 32'd40);
            chk("t5_hold_count", 32'(ooo_count), 32'd1);
        end
        disp(32'h1, TNONE, 32'h0, TNONE, 32'h0, 6'd42);
        flush = 1'b1;
        tick();
        idle();
        chk("t5_flush_valid", 32'(ino_valid), 32'd0);
        chk("t5_flush_count", 32'(ino_count), 32'd0);
        chk("t5_flush_ooo_count", 32'(ooo_count), 32'd0);
        issue_ready = 1'b1;
        repeat (3) tick();
        chk("t5_flush_stays_empty", 32'(ooo_valid), 32'd0);

        // Asynchronous reset in the middle of a stalled handshake.
        issue_ready = 1'b0;
        disp(32'hCAFE, TNONE, 32'h6000, TNONE, 32'h0, 6'd50);
        tick();
        idle();
        tick();
        chk("t6_pending_valid", 32'(ino_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("ino", ino_valid, ino_data, ino_addr, ino_rob, ino_count, ino_ready);
        chk_reset_vals("ooo", ooo_valid, ooo_data, ooo_addr, ooo_rob, ooo_count, ooo_ready);
        @(negedge clock);
        reset = 1'b1;
        issue_ready = 1'b1;
        repeat (2) tick();
        chk("t6_after_reset_valid", 32'(ino_valid), 32'd0);

        chk("ino_queue_empty", 32'(q_ino.size()), 32'd0);
        chk("ooo_queue_empty", 32'(q_ooo.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
